// File: rtl/ufr_pkg.sv
// Shared types and constants for universal_frame_receiver.
// Optional feature macro: UFR_PARITY_EN (adds the parity state).
package ufr_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef UFR_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } ufr_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd3
  } ufr_state_t;
`endif

endpackage

// File: rtl/universal_frame_receiver_if.sv
// Output word handshake between the receiver (master) and its consumer (slave).
interface universal_frame_receiver_if
  import ufr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] PO;
  logic              valid;
  logic              ready;

  modport master (output PO, output valid, input ready);
  modport slave  (input PO, input valid, output ready);

endinterface

// File: rtl/universal_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W payload bits MSB-first,
// optional even-parity bit (macro UFR_PARITY_EN), stop bit.
// The received word is offered on a valid/ready handshake.
//
// state | meaning
// IDLE  | line idle, waiting for a start bit
// DATA  | shifting in payload bits
// PAR   | sampling the parity bit (UFR_PARITY_EN only)
// STOP  | sampling the stop bit, deliver or discard the frame
module universal_frame_receiver
  import ufr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic SI,
  universal_frame_receiver_if.master out_if,
  output logic busy,
  output logic frm_err,
  output logic ovr_err,
  output logic par_err,
  input  logic clr_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  ufr_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              frame_good;
  logic              frm_ev;
  logic              ovr_ev;
  logic              par_bad;
`ifdef UFR_PARITY_EN
  logic              par_ev;
`endif

  assign busy   = (state != IDLE);
  assign ovr_ev = frame_good && out_if.valid && !out_if.ready;

  // State register; the FSM only advances on bit-enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= IDLE;
    else if (bit_en) state <= state_nxt;
  end

  // Next state and per-edge frame events.
  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frm_ev     = 1'b0;
`ifdef UFR_PARITY_EN
    par_ev     = 1'b0;
`endif
    case (state)
      IDLE: if (SI == START_LVL) state_nxt = DATA;
      DATA: begin
        if (cnt == LAST) begin
`ifdef UFR_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UFR_PARITY_EN
      PAR: begin
        state_nxt = STOP;
        par_ev    = bit_en && ((^shreg) ^ SI);
      end
`endif
      STOP: begin
        state_nxt  = IDLE;
        frame_good = bit_en && (SI == STOP_LVL) && !par_bad;
        frm_ev     = bit_en && (SI != STOP_LVL);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and shift register, frozen while bit_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (bit_en) begin
      if (state == IDLE && SI == START_LVL) cnt <= '0;
      if (state == DATA) begin
        shreg <= {shreg[DATA_W-2:0], SI};
        cnt   <= cnt + 1'b1;
      end
    end
  end

`ifdef UFR_PARITY_EN
  // Remember a parity mismatch until the stop bit decides the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
    end else if (bit_en) begin
      if (state == PAR)       par_bad <= par_ev;
      else if (state == IDLE) par_bad <= 1'b0;
    end
  end

  // Sticky parity error; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         par_err <= 1'b0;
    else if (par_ev)  par_err <= 1'b1;
    else if (clr_err) par_err <= 1'b0;
  end
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

  // Output word and handshake; runs every edge regardless of bit_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_if.PO    <= '0;
      out_if.valid <= 1'b0;
    end else if (frame_good && (!out_if.valid || out_if.ready)) begin
      out_if.PO    <= shreg;
      out_if.valid <= 1'b1;
    end else if (out_if.valid && out_if.ready) begin
      out_if.valid <= 1'b0;
    end
  end

  // Sticky framing and overrun errors; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if (frm_ev)       frm_err <= 1'b1;
      else if (clr_err) frm_err <= 1'b0;
      if (ovr_ev)       ovr_err <= 1'b1;
      else if (clr_err) ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_universal_frame_receiver.sv
// Directed testbench for universal_frame_receiver, DATA_W = 8.
module tb_universal_frame_receiver;
  import ufr_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic bit_en;
  logic SI;
  logic busy, frm_err, ovr_err, par_err;
  logic clr_err;

  int vectors = 0;
  int miscompares = 0;

  universal_frame_receiver_if #(.DATA_W(W)) bus ();

  universal_frame_receiver #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (bit_en),
    .SI      (SI),
    .out_if  (bus.master),
    .busy    (busy),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .par_err (par_err),
    .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SI     = b;
    bit_en = 1'b1;
    tick();
  endtask

  // Start, payload MSB-first, optional parity (even, xor par_flip), stop.
  task automatic send_frame(input logic [W-1:0] d, input logic stop,
                            input logic par_flip, input logic rdy_at_stop);
    logic pbit;
    pbit = (^d) ^ par_flip;
    send_bit(1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
`ifdef UFR_PARITY_EN
    send_bit(pbit);
`endif
    if (rdy_at_stop) bus.ready = 1'b1;
    send_bit(stop);
    if (rdy_at_stop) bus.ready = 1'b0;
    SI = IDLE_LVL;
  endtask

  task automatic drain();
    bus.ready = 1'b1;
    bit_en    = 1'b0;
    tick();
    bus.ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; SI = 1'b1; bit_en = 1'b0; bus.ready = 1'b0; clr_err = 1'b0;
    #12;
    vectors++; if (bus.PO !== 8'h00) begin miscompares++; $display("FAIL reset_po got %h want 00", bus.PO); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({frm_err, ovr_err, par_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {frm_err, ovr_err, par_err}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'hA5) begin miscompares++; $display("FAIL basic_po got %h want a5", bus.PO); end
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", bus.valid); end
    vectors++; if ({frm_err, ovr_err, par_err} !== 3'b000) begin miscompares++; $display("FAIL basic_flags got %b want 000", {frm_err, ovr_err, par_err}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b want 0", busy); end
    bus.ready = 1'b1; bit_en = 1'b0;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL basic_consume got %b want 0", bus.valid); end
    bus.ready = 1'b0;
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'h3C) begin miscompares++; $display("FAIL ovr_po got %h want 3c", bus.PO); end
    vectors++; if (ovr_err !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", ovr_err); end
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b want 1", bus.valid); end
    bus.ready = 1'b1; bit_en = 1'b0;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL ovr_consume got %b want 0", bus.valid); end
    bus.ready = 1'b0;
    clear_flags();
    vectors++; if (ovr_err !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b want 0", ovr_err); end
  endtask

  task automatic test_back_to_back();
    bus.ready = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'h11 || bus.valid !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %h/%b want 11/1", bus.PO, bus.valid); end
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'h22 || bus.valid !== 1'b1) begin miscompares++; $display("FAIL b2b_second got %h/%b want 22/1", bus.PO, bus.valid); end
    drain();
    // consume and new word on the same edge
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1);
    vectors++; if (bus.PO !== 8'h44 || bus.valid !== 1'b1) begin miscompares++; $display("FAIL same_edge got %h/%b want 44/1", bus.PO, bus.valid); end
    vectors++; if (ovr_err !== 1'b0) begin miscompares++; $display("FAIL same_edge_ovr got %b want 0", ovr_err); end
    drain();
  endtask

  task automatic test_frame_err();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    vectors++; if (frm_err !== 1'b1) begin miscompares++; $display("FAIL frm_flag got %b want 1", frm_err); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL frm_valid got %b want 0", bus.valid); end
    bit_en = 1'b0;
    clear_flags();
    vectors++; if (frm_err !== 1'b0) begin miscompares++; $display("FAIL frm_clear got %b want 0", frm_err); end
    clr_err = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    vectors++; if (frm_err !== 1'b1) begin miscompares++; $display("FAIL frm_vs_clear got %b want 1", frm_err); end
    tick();
    vectors++; if (frm_err !== 1'b1) begin miscompares++; $display("FAIL frm_sticky got %b want 1", frm_err); end
    clear_flags();
  endtask

`ifdef UFR_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    vectors++; if (par_err !== 1'b1) begin miscompares++; $display("FAIL par_flag got %b want 1", par_err); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL par_discard got %b want 0", bus.valid); end
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'h01 || bus.valid !== 1'b1) begin miscompares++; $display("FAIL par_good got %h/%b want 01/1", bus.PO, bus.valid); end
    clear_flags();
    vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL par_clear got %b want 0", par_err); end
    drain();
  endtask
`endif

  task automatic test_bit_en_gap();
    logic [W+1:0] frame;
    logic [W-1:0] d;
    d = 8'h5A;
`ifdef UFR_PARITY_EN
    frame = {1'b0, d, 1'b1};
    send_bit(1'b0); bit_en = 1'b0; tick();
    for (int i = W - 1; i >= 0; i--) begin send_bit(d[i]); bit_en = 1'b0; tick(); end
    send_bit(^d); bit_en = 1'b0; tick();
    send_bit(1'b1); bit_en = 1'b0; tick();
`else
    frame = {1'b0, d, 1'b1};
    for (int i = W + 1; i >= 0; i--) begin
      send_bit(frame[i]);
      bit_en = 1'b0;
      tick();
    end
`endif
    vectors++; if (bus.PO !== 8'h5A || bus.valid !== 1'b1) begin miscompares++; $display("FAIL gap_word got %h/%b want 5a/1", bus.PO, bus.valid); end
    bus.ready = 1'b1;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL gap_handshake got %b want 0", bus.valid); end
    bus.ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    vectors++; if (busy !== 1'b1 || frm_err !== 1'b1 || ovr_err !== 1'b1 || bus.valid !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset got busy%b frm%b ovr%b v%b want 1111", busy, frm_err, ovr_err, bus.valid); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.PO !== 8'h00 || bus.valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_out got %h/%b want 00/0", bus.PO, bus.valid); end
    vectors++; if ({busy, frm_err, ovr_err, par_err} !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_flags got %b want 0000", {busy, frm_err, ovr_err, par_err}); end
    tick();
    rst = 1'b1;
    SI  = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    vectors++; if (busy !== 1'b0 || bus.valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got %b/%b want 0/0", busy, bus.valid); end
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    vectors++; if (bus.PO !== 8'hC3 || bus.valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_frame got %h/%b want c3/1", bus.PO, bus.valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_frame_err();
`ifdef UFR_PARITY_EN
    test_parity();
`endif
    test_bit_en_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/universal_frame_receiver.md
UNIVERSAL_FRAME_RECEIVER -- requirements
Module: universal_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (legal range 4..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port bit_en  input  1  qualifies SI; a bit is consumed only on edges where bit_en=1.
REQ-005 SHALL have port SI  input  1  serial line (idle high), fed by an upstream shift register's SO.
REQ-006 SHALL have port PO  output  DATA_W  received payload, valid only while valid=1.
REQ-007 SHALL have port valid  output  1  PO holds an unconsumed word.
REQ-008 SHALL have port ready  input  1  consumer accepts PO when valid&&ready on a rising edge.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have ports frm_err, ovr_err, par_err  output  1 each  sticky error flags.
REQ-011 SHALL have port clr_err  input  1  synchronous clear of all sticky error flags.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, PAR, STOP; state changes only on edges with bit_en=1.
REQ-013 IDLE: bit_en&&SI=0 -> DATA with bit counter=0; SI=1 -> stay IDLE.
REQ-014 DATA: shift SI into the shift register LSB (left shift); the first received bit ends as PO[DATA_W-1] (MSB-first).
REQ-015 DATA: after DATA_W bits -> PAR if PARITY_EN is defined, else -> STOP.
REQ-016 PAR: sample parity bit -> STOP; even parity: XOR of payload and parity bit SHALL be 0.
REQ-017 STOP: SI=1 and no parity error -> frame good; SI=0 -> frm_err<=1, frame discarded; always -> IDLE.
REQ-018 A good frame SHALL load PO and set valid on the same edge that samples the stop bit (latency: 0 cycles after stop-bit edge).
REQ-019 valid SHALL clear on an edge with valid&&ready, unless a good frame completes on that same edge, in which case PO takes the new word and valid stays 1.
REQ-020 A good frame arriving while valid=1 and ready=0 SHALL be dropped, PO unchanged, ovr_err<=1.
REQ-021 Parity mismatch SHALL set par_err and discard the frame; PO/valid unaffected.
REQ-022 clr_err SHALL clear flags; an error event on the same edge SHALL win (flag ends 1).
REQ-023 bit_en=0 SHALL freeze FSM, counter and shift register; handshake (REQ-019) still operates.
REQ-024 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, counter=0, shift register=0, PO=0, valid=0, busy=0, all error flags=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh start bit.

Configuration
REQ-027 Macro UFR_PARITY_EN SHALL compile in the PAR state and parity check (frame = 1+DATA_W+1+1 bits).
REQ-028 Without UFR_PARITY_EN the PAR state SHALL not exist, frame = 1+DATA_W+1 bits, par_err tied to 0.

Structure
REQ-029 Package ufr_pkg SHALL hold the FSM state typedef, START_LVL=0, STOP_LVL=1, IDLE_LVL=1, and the DATA_W default.
REQ-030 Block SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-031 DATA_W=8, no parity, frame 0,1,0,1,0,0,1,0,1,1 with bit_en=1 every cycle -> PO=8'hA5, valid=1 on stop edge, no flags.
REQ-032 Two consecutive frames 8'h3C, 8'hC3 with ready=0 -> PO=8'h3C held, ovr_err=1; then ready=1 -> valid clears next edge.
REQ-033 Stop bit 0 after payload 8'hFF -> frm_err=1, valid stays 0; clr_err pulse -> frm_err=0.
REQ-034 UFR_PARITY_EN, payload 8'h01 with parity bit 0 -> par_err=1, frame discarded; parity bit 1 -> PO=8'h01, valid=1.
REQ-035 bit_en toggling 1/0 every cycle during frame 8'h5A -> PO=8'h5A after 20 clocks; rst=0 at bit 4 of a later frame -> all outputs 0 immediately.
